rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//   Shares the single register-file write port between the in-order writeback stage and a
//   long-latency unit (LL: divider/multiplier). LL results wait in a small FIFO.
//   The FIFO drains into write cycles the WB stage leaves free. A starvation counter and a
//   same-destination ordering rule force a drain when needed. Sits between wb_stage and regfile.
// PARAMETERS
//   DEPTH       2   LL result FIFO entries (power of 2, >=2)
//   STARVE_MAX  4   max consecutive cycles a non-empty FIFO loses arbitration
// PORTS
//   clk            in   1   clock, rising edge
//   resetn         in   1   asynchronous reset, active low
//   ws_rf_we       in   1   WB stage requests an RF write this cycle
//   ws_rf_waddr    in   5   WB destination register
//   ws_rf_wdata    in   32  WB write data
//   ws_stall       out  1   WB write not granted; WB holds its instruction (gates ws_ready_go)
//   ll_valid       in   1   LL result available
//   ll_ready       out  1   FIFO accepts the LL result
//   ll_waddr       in   5   LL destination register
//   ll_wdata       in   32  LL result data
//   rf_we          out  1   regfile write enable
//   rf_waddr       out  5   regfile write address
//   rf_wdata       out  32  regfile write data
//   rf_src         out  1   0 = WB granted, 1 = FIFO head granted
//   ds_query_addr  in   5   decode-stage source register to check
//   ds_query_pend  out  1   ds_query_addr matches a valid FIFO entry (nonzero addr)
// BEHAVIOUR
//   - Reset (resetn=0, async): FIFO empty, pointers 0, starve_cnt 0.
//     While in reset: rf_we=0, ws_stall=0, ll_ready=0, ds_query_pend=0.
//   - Push: ll_valid && ll_ready at the clock edge. ll_ready = (count < DEPTH).
//     A full FIFO deasserts ll_ready even if it pops the same cycle.
//   - Pushed entry is visible to arbitration the cycle after the push; no same-cycle bypass.
//   - Grant, evaluated combinationally each cycle:
//       fifo_go = !empty && (!ws_rf_we || starve_cnt==STARVE_MAX || waw_hit)
//       waw_hit = ws_rf_we && any valid entry has waddr == ws_rf_waddr (program order)
//   - When fifo_go=1: rf_* come from the FIFO head, rf_src=1, the head pops at the edge,
//     and ws_stall = ws_rf_we.
//   - When fifo_go=0: rf_* = ws_*, rf_we = ws_rf_we, rf_src=0, ws_stall=0.
//   - rf_we is forced to 0 when the granted address is 0. The $0 entry still pops, or the WB
//     slot is still consumed.
//   - starve_cnt:
//       reset to 0 on a FIFO pop or when empty;
//       +1 when the FIFO is non-empty and WB wins;
//       saturates at STARVE_MAX.
//   - Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
//   - ds_query_pend is combinational over valid entries. An entry popping this cycle still
//     reports pending (the RF write lands at the edge).
//   - No output is registered except FIFO/counter state. WB-to-RF latency 0; FIFO-to-RF
//     latency >=1 cycle.
// TESTING
//   1 Idle FIFO: ws_rf_we=1, waddr=5, wdata=0x1234 ->
//     same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, rf_src=0, ws_stall=0.
//   2 LL push with WB idle: ll_waddr=8, ll_wdata=0xDEAD at cycle N ->
//     cycle N+1 rf_we=1, rf_waddr=8, rf_src=1; FIFO empty at N+2.
//   3 Starvation: FIFO holds 1 entry; WB writes r3..r9 back-to-back ->
//     4 WB grants, then 1 cycle with rf_src=1 and ws_stall=1; WB resumes next cycle.
//   4 WAW: FIFO holds waddr=7; ws_rf_we=1, ws_rf_waddr=7 ->
//     FIFO write first with ws_stall=1; next cycle WB write to r7 with rf_src=0.
//   5 Full: push 2 entries while WB is busy every cycle -> ll_ready=0 with count=2.
//     ds_query_addr set to either waddr -> ds_query_pend=1; ds_query_addr=0 -> 0.
//   6 Async reset mid-drain: resetn low between edges with 2 entries queued ->
//     rf_we=0 and ll_ready=0 immediately; after release FIFO is empty and starve_cnt=0.
//     LL entry with waddr=0 -> pops with rf_we=0.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB stage vs. queued long-latency results.
// LL results drain into free WB slots; starvation and WAW ordering force a drain.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_rf_we,
    input  logic [4:0]  ws_rf_waddr,
    input  logic [31:0] ws_rf_wdata,
    output logic        ws_stall,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_waddr,
    input  logic [31:0] ll_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_src,
    input  logic [4:0]  ds_query_addr,
    output logic        ds_query_pend
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic empty;
    logic full;
    logic waw_hit;
    logic query_hit;
    logic starved;
    logic fifo_go;
    logic push;
    logic pop;
    logic grant_we;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign starved = (starve_cnt == SW'(STARVE_MAX));

    // Ordering and decode-query lookups only consider live entries.
    always_comb begin
        waw_hit   = 1'b0;
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == ws_rf_waddr) && ws_rf_we)
                waw_hit = 1'b1;
            if (ent_vld[i] && (ent_addr[i] == ds_query_addr) && (ds_query_addr != 5'd0))
                query_hit = 1'b1;
        end
    end

    assign fifo_go = !empty && (!ws_rf_we || starved || waw_hit);
    assign pop     = fifo_go;
    assign push    = ll_valid && ll_ready;

    always_comb begin
        rf_src   = 1'b0;
        rf_waddr = ws_rf_waddr;
        rf_wdata = ws_rf_wdata;
        grant_we = ws_rf_we;
        if (fifo_go) begin
            rf_src   = 1'b1;
            rf_waddr = ent_addr[rd_ptr];
            rf_wdata = ent_data[rd_ptr];
            grant_we = 1'b1;
        end
    end

    // Outputs are held quiet while reset is asserted, independent of the clock.
    assign rf_we         = resetn && grant_we && (rf_waddr != 5'd0);
    assign ws_stall      = resetn && fifo_go && ws_rf_we;
    assign ll_ready      = resetn && !full;
    assign ds_query_pend = resetn && query_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ent_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            // A push never targets the head slot being popped: push needs !full, pop needs !empty.
            if (push) begin
                ent_addr[wr_ptr] <= ll_waddr;
                ent_data[wr_ptr] <= ll_wdata;
                ent_vld[wr_ptr]  <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: per-cycle vector table plus reset and starvation sequences.
module tb_rf_wport_arbiter;

    logic        clk;
    logic        resetn;
    logic        ws_rf_we;
    logic [4:0]  ws_rf_waddr;
    logic [31:0] ws_rf_wdata;
    logic        ws_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic [4:0]  ds_query_addr;
    logic        ds_query_pend;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ws_rf_we      (ws_rf_we),
        .ws_rf_waddr   (ws_rf_waddr),
        .ws_rf_wdata   (ws_rf_wdata),
        .ws_stall      (ws_stall),
        .ll_valid      (ll_valid),
        .ll_ready      (ll_ready),
        .ll_waddr      (ll_waddr),
        .ll_wdata      (ll_wdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_src        (rf_src),
        .ds_query_addr (ds_query_addr),
        .ds_query_pend (ds_query_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ws_we;
        logic [4:0]  ws_addr;
        logic [31:0] ws_data;
        logic        ll_v;
        logic [4:0]  ll_addr;
        logic [31:0] ll_data;
        logic [4:0]  q;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_src;
        logic        e_stall;
        logic        e_ready;
        logic        e_pend;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd,
                                logic lv, logic [4:0] la, logic [31:0] ld, logic [4:0] q,
                                logic ew, logic [4:0] ea, logic [31:0] ed,
                                logic es, logic est, logic er, logic ep);
        vec_t v;
        v.ws_we = w;  v.ws_addr = wa; v.ws_data = wd;
        v.ll_v  = lv; v.ll_addr = la; v.ll_data = ld; v.q = q;
        v.e_we  = ew; v.e_addr  = ea; v.e_data  = ed;
        v.e_src = es; v.e_stall = est; v.e_ready = er; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic [4:0] q);
        ws_rf_we = w;  ws_rf_waddr = wa; ws_rf_wdata = wd;
        ll_valid = lv; ll_waddr = la;    ll_wdata = ld;
        ds_query_addr = q;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;

        // Table rows are consecutive cycles; FIFO state carries from row to row.
        vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0, 0,           1, 5, 32'h1234, 0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 1, 8, 32'hDEAD, 8,           0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 8,                  1, 8, 32'hDEAD, 1, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 8,                  0, 0, 0, 0, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 1, 20, 32'hA5A5, 20,         0, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(1, 3, 3, 0, 0, 0, 20,                 1, 3, 3, 0, 0, 1, 1);
        vecs[6]  = mk(1, 4, 4, 0, 0, 0, 20,                 1, 4, 4, 0, 0, 1, 1);
        vecs[7]  = mk(1, 5, 5, 0, 0, 0, 20,                 1, 5, 5, 0, 0, 1, 1);
        vecs[8]  = mk(1, 6, 6, 0, 0, 0, 20,                 1, 6, 6, 0, 0, 1, 1);
        vecs[9]  = mk(1, 7, 7, 0, 0, 0, 20,                 1, 20, 32'hA5A5, 1, 1, 1, 1);
        vecs[10] = mk(1, 7, 7, 0, 0, 0, 20,                 1, 7, 7, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 1, 7, 32'h77, 7,             0, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(1, 7, 32'h700, 0, 0, 0, 7,            1, 7, 32'h77, 1, 1, 1, 1);
        vecs[13] = mk(1, 7, 32'h700, 0, 0, 0, 7,            1, 7, 32'h700, 0, 0, 1, 0);
        vecs[14] = mk(1, 1, 32'h11, 1, 10, 32'hA0, 10,      1, 1, 32'h11, 0, 0, 1, 0);
        vecs[15] = mk(1, 2, 32'h22, 1, 11, 32'hB0, 10,      1, 2, 32'h22, 0, 0, 1, 1);
        vecs[16] = mk(1, 3, 32'h33, 1, 12, 32'hC0, 11,      1, 3, 32'h33, 0, 0, 0, 1);
        vecs[17] = mk(1, 4, 32'h44, 0, 0, 0, 0,             1, 4, 32'h44, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 10,                 1, 10, 32'hA0, 1, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 10,                 1, 11, 32'hB0, 1, 0, 1, 0);
        vecs[20] = mk(0, 0, 0, 1, 13, 32'hD0, 13,           0, 0, 0, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 0, 1, 14, 32'hE0, 13,           1, 13, 32'hD0, 1, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 14,                 1, 14, 32'hE0, 1, 0, 1, 1);
        vecs[23] = mk(0, 0, 0, 1, 0, 32'hFF, 0,             0, 0, 0, 0, 0, 1, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'hFF, 1, 0, 1, 0);
        vecs[25] = mk(1, 9, 32'h99, 0, 0, 0, 0,             1, 9, 32'h99, 0, 0, 1, 0);
        vecs[26] = mk(1, 0, 32'h55, 0, 0, 0, 0,             0, 0, 32'h55, 0, 0, 1, 0);

        resetn = 1'b0;
        drive(1, 5'd4, 32'h4, 1, 5'd6, 32'h6, 5'd6);
        #3;
        chk("rst_rf_we",    32'(rf_we),         32'd0);
        chk("rst_ws_stall", 32'(ws_stall),      32'd0);
        chk("rst_ll_ready", 32'(ll_ready),      32'd0);
        chk("rst_pend",     32'(ds_query_pend), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].ws_we, vecs[i].ws_addr, vecs[i].ws_data,
                  vecs[i].ll_v, vecs[i].ll_addr, vecs[i].ll_data, vecs[i].q);
            @(negedge clk);
            chk($sformatf("v%0d_rf_we", i),    32'(rf_we),         32'(vecs[i].e_we));
            chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr),      32'(vecs[i].e_addr));
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata,           vecs[i].e_data);
            chk($sformatf("v%0d_rf_src", i),   32'(rf_src),        32'(vecs[i].e_src));
            chk($sformatf("v%0d_ws_stall", i), 32'(ws_stall),      32'(vecs[i].e_stall));
            chk($sformatf("v%0d_ll_ready", i), 32'(ll_ready),      32'(vecs[i].e_ready));
            chk($sformatf("v%0d_pend", i),     32'(ds_query_pend), 32'(vecs[i].e_pend));
        end

        // Fill the FIFO behind a busy WB stage, then reset between edges.
        @(posedge clk); #1;
        drive(1, 5'd1, 32'h1, 1, 5'd21, 32'h210, 5'd0);
        @(posedge clk); #1;
        drive(1, 5'd2, 32'h2, 1, 5'd22, 32'h220, 5'd0);
        @(posedge clk); #1;
        drive(1, 5'd3, 32'h3, 0, 5'd0, 32'h0, 5'd21);
        #1;
        chk("pre_rst_pend",  32'(ds_query_pend), 32'd1);
        chk("pre_rst_ready", 32'(ll_ready),      32'd0);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_rf_we",    32'(rf_we),         32'd0);
        chk("async_ll_ready", 32'(ll_ready),      32'd0);
        chk("async_ws_stall", 32'(ws_stall),      32'd0);
        chk("async_pend",     32'(ds_query_pend), 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5'd21);
        #1;
        chk("post_rst_rf_we", 32'(rf_we),         32'd0);
        chk("post_rst_src",   32'(rf_src),        32'd0);
        chk("post_rst_pend",  32'(ds_query_pend), 32'd0);
        chk("post_rst_ready", 32'(ll_ready),      32'd1);

        // One queued entry must lose exactly STARVE_MAX WB grants before it is forced out.
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 5'd23, 32'h230, 5'd23);
        @(posedge clk); #1;
        drive(1, 5'd1, 32'h1, 0, 0, 0, 5'd23);
        grants = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rf_src) begin
                grants = k;
                chk("starve_stall", 32'(ws_stall), 32'd1);
                chk("starve_addr",  32'(rf_waddr), 32'd23);
                break;
            end
            @(posedge clk); #1;
            ws_rf_waddr = 5'(k + 2);
            ws_rf_wdata = 32'(k + 2);
        end
        chk("starve_grants", 32'(grants), 32'd4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_src",   32'(rf_src),   32'd0);
        chk("resume_we",    32'(rf_we),    32'd1);
        chk("resume_stall", 32'(ws_stall), 32'd0);
        chk("resume_pend",  32'(ds_query_pend), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
